// File: rtl/matmul_run_sequencer.sv
// Run-level sequencer for the 8x8 matmul-with-RAM datapath: streams A/B words into the
// BRAMs, runs the systolic engine, then drains C through a credit-limited output FIFO.
module matmul_run_sequencer #(
    parameter int DWIDTH          = 16,
    parameter int BB              = 4,
    parameter int AWIDTH          = 7,
    parameter int A_WORDS         = 8,
    parameter int B_WORDS         = 8,
    parameter int C_WORDS         = 8,
    parameter int WR_ALIGN        = 2,
    parameter int RD_LAT          = 4,
    parameter int COMPUTE_TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cfg_start,
    input  logic [BB*DWIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BB*DWIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   run_done,
    output logic                   err_timeout,
    output logic [AWIDTH-1:0]      mm_addr_pi,
    output logic [BB*DWIDTH-1:0]   mm_data_pi,
    output logic                   mm_we_a,
    output logic                   mm_we_b,
    output logic                   mm_we_c,
    output logic                   mm_enable_writing_to_mem,
    output logic                   mm_enable_reading_from_mem,
    output logic                   mm_start_mat_mul_0,
    input  logic                   mm_done_mat_mul,
    input  logic [BB*DWIDTH-1:0]   mm_data_from_out_mat
);
    // state   | meaning
    // IDLE    | waiting for cfg_start
    // LOAD_A  | accepting A words
    // LOAD_B  | accepting B words
    // FLUSH   | draining the write-alignment pipe
    // COMPUTE | engine running, C writes enabled
    // READ    | reading C back onto the output stream
    // DONE    | one-cycle run_done
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FLUSH, COMPUTE, READ, DONE} state_t;

    localparam int W          = BB*DWIDTH;
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int TW         = $clog2(COMPUTE_TIMEOUT + 1);
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int L          = WR_ALIGN - 1;
    localparam logic [AWIDTH-1:0] A_LAST = AWIDTH'(A_WORDS - 1);
    localparam logic [AWIDTH-1:0] B_LAST = AWIDTH'(B_WORDS - 1);
    localparam logic [AWIDTH-1:0] C_LAST = AWIDTH'(C_WORDS - 1);
    localparam logic [TW-1:0]     T_MAX  = TW'(COMPUTE_TIMEOUT);
    localparam logic [PW-1:0]     P_LAST = PW'(FIFO_DEPTH - 1);

    state_t state, state_nx;

    logic [AWIDTH-1:0] wcnt, rcnt, ocnt;
    logic [TW-1:0]     tcnt;

    logic              wr_en_q, wr_sel_a_q;
    logic [AWIDTH-1:0] wr_addr_q;
    logic [W-1:0]      wr_data_q;
    logic [WR_ALIGN-1:0] wp_valid, wp_sel_a;
    logic [W-1:0]      wp_data [WR_ALIGN];

    logic [RD_LAT-1:0] rd_pipe;
    logic [W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_count, in_flight;
    logic [CW:0]       occupancy;

    logic accept, wr_drain, rd_issue, push, pop, timeout;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(rd_pipe[i]);
        wr_drain = !wr_en_q;
        for (int i = 0; i < WR_ALIGN - 1; i++) if (wp_valid[i]) wr_drain = 1'b0;
    end

    assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = rd_pipe[RD_LAT-1];

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        rd_issue = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE:    if (cfg_start) state_nx = LOAD_A;
            LOAD_A: begin
                in_ready = (int'(wcnt) < A_WORDS);
                if (in_valid && in_ready && wcnt == A_LAST) state_nx = LOAD_B;
            end
            LOAD_B: begin
                in_ready = (int'(wcnt) < B_WORDS);
                if (in_valid && in_ready && wcnt == B_LAST) state_nx = FLUSH;
            end
            FLUSH:   if (wr_drain) state_nx = COMPUTE;
            COMPUTE: begin
                // done takes priority over a timeout landing in the same cycle
                if (mm_done_mat_mul) begin
                    state_nx = READ;
                end else if (tcnt == T_MAX) begin
                    timeout  = 1'b1;
                    state_nx = DONE;
                end
            end
            READ: begin
                rd_issue = (int'(rcnt) < C_WORDS) && (occupancy < (CW+1)'(FIFO_DEPTH));
                if (pop && ocnt == C_LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        accept = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            wcnt        <= '0;
            rcnt        <= '0;
            ocnt        <= '0;
            tcnt        <= '0;
            err_timeout <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_sel_a_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wp_valid    <= '0;
            wp_sel_a    <= '0;
            for (int i = 0; i < WR_ALIGN; i++) wp_data[i] <= '0;
            rd_pipe     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cfg_start) begin
                wcnt        <= '0;
                rcnt        <= '0;
                ocnt        <= '0;
                tcnt        <= '0;
                err_timeout <= 1'b0;
            end
            if (accept) wcnt <= (state_nx == state) ? wcnt + 1'b1 : '0;
            if (state == FLUSH && wr_drain) tcnt <= TW'(1);
            else if (state == COMPUTE)      tcnt <= tcnt + 1'b1;
            if (timeout)  err_timeout <= 1'b1;
            if (rd_issue) rcnt <= rcnt + 1'b1;
            if (pop)      ocnt <= ocnt + 1'b1;

            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q  <= wcnt;
                wr_data_q  <= in_data;
                wr_sel_a_q <= (state == LOAD_A);
            end
            wp_valid[0] <= wr_en_q;
            wp_sel_a[0] <= wr_sel_a_q;
            wp_data[0]  <= wr_data_q;
            for (int i = 1; i < WR_ALIGN; i++) begin
                wp_valid[i] <= wp_valid[i-1];
                wp_sel_a[i] <= wp_sel_a[i-1];
                wp_data[i]  <= wp_data[i-1];
            end

            rd_pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (push) wr_ptr <= (wr_ptr == P_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == P_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mm_data_from_out_mat;
    end

    assign out_data                   = out_valid ? fifo_mem[rd_ptr] : '0;
    assign busy                       = (state != IDLE);
    assign run_done                   = (state == DONE);
    assign mm_addr_pi                 = (state == READ) ? rcnt : (wr_en_q ? wr_addr_q : '0);
    assign mm_enable_writing_to_mem   = wr_en_q;
    assign mm_data_pi                 = wp_valid[L] ? wp_data[L] : '0;
    assign mm_we_a                    = wp_valid[L] & wp_sel_a[L];
    assign mm_we_b                    = wp_valid[L] & ~wp_sel_a[L];
    assign mm_start_mat_mul_0         = (state == COMPUTE);
    assign mm_we_c                    = (state == COMPUTE);
    assign mm_enable_reading_from_mem = (state == READ);
endmodule
